run_light_multi: RTL

Parametrised running-light generator: a WIDTH-bit one-hot/bar pattern register advanced by a programmable prescaler, with four display modes (rotate left, rotate right, bounce, fill/clear), an enable/pause input, and step/wrap status pulses. It is the next generation of the team's 8-bit, 2-bit-mode running-light block. It drives LED banks directly or feeds a display mux.

---
 rtl/run_light_multi.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/run_light_multi.sv
// Running-light pattern generator: WIDTH-bit pattern advanced every DIV
// enabled cycles in one of four modes (rotate left/right, bounce, fill/clear),
// with registered step/wrap pulses marking each advance and each new period.
module run_light_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y,
  output logic             step,
  output logic             wrap
);

  localparam int unsigned     PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {
    ROTL   = 2'd0,
    ROTR   = 2'd1,
    BOUNCE = 2'd2,
    FILL   = 2'd3
  } mode_t;

  mode_t            s_q, s_d;
  logic             dir_q, dir_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             mode_chg;
  logic [WIDTH-1:0] y_start;
  logic [WIDTH-1:0] y_adv;
  logic             dir_adv;
  logic             wrap_adv;

  assign mode_chg = (S != s_q);

  // State register: pattern, prescaler, registered mode, bounce direction, pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q    <= ROTL;
      dir_q  <= 1'b0;
      pcnt_q <= '0;
      y_q    <= ONE;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      dir_q  <= dir_d;
      pcnt_q <= pcnt_d;
      y_q    <= y_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Start pattern of the mode being switched into
  always_comb begin
    y_start = ONE;
    unique case (mode_t'(S))
      ROTR:    y_start = MSB;
      FILL:    y_start = '0;
      default: y_start = ONE;
    endcase
  end

  // One step of the current mode: next pattern, next direction, period-start flag
  always_comb begin
    y_adv    = y_q;
    dir_adv  = dir_q;
    wrap_adv = 1'b0;
    unique case (s_q)
      ROTL: begin
        y_adv    = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
        wrap_adv = y_q[WIDTH-1];
      end
      ROTR: begin
        y_adv    = {y_q[0], y_q[WIDTH-1:1]};
        wrap_adv = y_q[0];
      end
      BOUNCE: begin
        // Direction flips on the step that lands on an end bit, so no dwell.
        if (!dir_q) begin
          y_adv   = y_q << 1;
          dir_adv = y_q[WIDTH-2];
        end else begin
          y_adv    = y_q >> 1;
          dir_adv  = ~y_q[1];
          wrap_adv = y_q[1];
        end
      end
      FILL: begin
        if (&y_q) begin
          y_adv    = '0;
          wrap_adv = 1'b1;
        end else begin
          y_adv = {y_q[WIDTH-2:0], 1'b1};
        end
      end
      default: begin
        y_adv = y_q;
      end
    endcase
  end

  // Next state: mode change beats tick; pause holds prescaler and pattern
  always_comb begin
    s_d    = s_q;
    dir_d  = dir_q;
    pcnt_d = pcnt_q;
    y_d    = y_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg) begin
      s_d    = mode_t'(S);
      y_d    = y_start;
      pcnt_d = '0;
      dir_d  = 1'b0;
    end else if (en) begin
      if (pcnt_q == PMAX) begin
        pcnt_d = '0;
        y_d    = y_adv;
        dir_d  = dir_adv;
        step_d = 1'b1;
        wrap_d = wrap_adv;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    Y    = y_q;
    step = step_q;
    wrap = wrap_q;
  end

endmodule
